inst_fetch_queue: RTL and testbench

- Fetch stage directly downstream of programCounter.
- Takes the current PC, issues a read to synchronous instruction memory (1-cycle read latency), and buffers {pc, instr} pairs in a small FIFO.
- Presents the pairs to decode with a valid/ready handshake.
- Back-pressures the PC via pc_ready, and supports a flush for branch/jump redirects.

---
 rtl/mips_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/inst_fetch_queue.sv | 112 +++++++++++
 tb/tb_inst_fetch_queue.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-path types and constants.
package mips_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0000;

    // One queued fetch result: the PC it was fetched from and the word returned.
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetch entries with push/pop/flush and an occupancy count.
// Pointers wrap naturally because DEPTH is a power of two.
module fetch_fifo
    import mips_pkg::fetch_entry_t;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    // Next pointers and count; flush wins over any simultaneous push or pop.
    always_comb begin
        push_ok  = push && (count_q != CNT_W'(DEPTH));
        pop_ok   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
            count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // Pointer and count state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are qualified by count so it needs no reset.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage: issues PC reads to a 1-cycle synchronous instruction memory and
// queues {pc, instr} pairs toward decode with valid/ready.
// Optional feature macro: FETCH_BYPASS_EN -- forwards a returning response
// straight to decode when the queue is empty, cutting latency by one cycle.
// ADDR_W/DATA_W must match the widths of mips_pkg::fetch_entry_t.
module inst_fetch_queue
    import mips_pkg::fetch_entry_t;
    import mips_pkg::NOP_INSTR;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = mips_pkg::ADDR_W,
    parameter int unsigned DATA_W = mips_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              pc_valid,
    output logic              pc_ready,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              out_misalign
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              started_q;
    logic              inflight_q;
    logic [ADDR_W-1:0] cap_pc_q;
    logic              accept;
    logic              bypass;
    logic              fifo_valid;
    logic              push, pop;
    logic [CNT_W-1:0]  count;
    fetch_entry_t      push_data;
    fetch_entry_t      head;

    // Request side: a slot is reserved for every accepted fetch via inflight.
    // started_q holds requests off until the first edge after reset release.
    always_comb begin
        pc_ready  = started_q && !flush &&
                    ((count + CNT_W'(inflight_q)) < CNT_W'(DEPTH));
        accept    = pc_valid && pc_ready;
        imem_req  = accept;
        imem_addr = pc;
    end

`ifdef FETCH_BYPASS_EN
    assign bypass = (count == '0) && inflight_q && !flush;
`else
    assign bypass = 1'b0;
`endif

    // Queue control: a bypassed response taken by decode is never stored.
    always_comb begin
        fifo_valid = (count != '0);
        push       = inflight_q && !flush && !(bypass && out_ready);
        pop        = fifo_valid && out_ready && !flush;
        push_data  = '{pc: cap_pc_q, instr: imem_rdata};
    end

    // Output mux: bypass path, FIFO head, or NOP with zero PC when empty.
    always_comb begin
        out_valid = 1'b0;
        out_instr = NOP_INSTR;
        out_pc    = '0;
        if (bypass) begin
            out_valid = 1'b1;
            out_instr = imem_rdata;
            out_pc    = cap_pc_q;
        end else if (fifo_valid) begin
            out_valid = 1'b1;
            out_instr = head.instr;
            out_pc    = head.pc;
        end
        out_misalign = out_valid && (out_pc[1:0] != 2'b00);
    end

    // Outstanding-read tracking and PC capture for the response cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            started_q  <= 1'b0;
            inflight_q <= 1'b0;
            cap_pc_q   <= '0;
        end else begin
            started_q  <= 1'b1;
            inflight_q <= accept;
            if (accept) begin
                cap_pc_q <= pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (flush),
        .head      (head),
        .count     (count)
    );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: accepted fetches queue their expected
// {pc, instr, misalign}; a monitor checks every consumed output in order.
module tb_inst_fetch_queue;

`ifdef FETCH_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        pc_valid;
    logic        pc_ready;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_misalign;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    inst_fetch_queue #(
        .DEPTH  (4),
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .pc_valid     (pc_valid),
        .pc_ready     (pc_ready),
        .flush        (flush),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_misalign (out_misalign)
    );

    always #5 clk = ~clk;

    // Memory contents: word at address a is {a[15:0]^16'h1234, ~a[15:0]}.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h1234, ~a[15:0]};
    endfunction

    // Synchronous instruction memory, one-cycle read latency.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= mem_word(imem_addr);
    end

    task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Stimulus side of the scoreboard: record accepts, drop everything on flush/reset.
    always @(negedge clk) begin
        if (!reset || flush) begin
            exp_q.delete();
        end else if (pc_valid && pc_ready) begin
            exp_q.push_back('{pc: pc, instr: mem_word(pc), mis: (pc[1:0] != 2'b00)});
        end
    end

    // Monitor: compare each consumed head, and require zeros while idle.
    always @(negedge clk) begin
        if (reset && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", {71'h0, out_valid}, 72'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_entry", {8'h0, out_pc, out_instr}, {8'h0, e.pc, e.instr});
                check("sb_misalign", {71'h0, out_misalign}, {71'h0, e.mis});
            end
        end else if (!out_valid) begin
            check("idle_zero", {7'h0, out_pc, out_instr, out_misalign}, 72'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the next valid output cycle and report it.
    task automatic wait_out(output logic [31:0] got_pc, output logic got_mis);
        got_pc  = 32'hdead_beef;
        got_mis = 1'bx;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got_pc  = out_pc;
                got_mis = out_misalign;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int          acc;
        logic [31:0] gpc;
        logic        gmis;

        reset = 1'b0; pc = 32'h0; pc_valid = 1'b1; flush = 1'b0; out_ready = 1'b0;

        // Reset held with a valid PC: everything quiet.
        repeat (2) @(negedge clk);
        check("rst_pc_ready", {71'h0, pc_ready}, 72'h0);
        check("rst_imem_req", {71'h0, imem_req}, 72'h0);
        check("rst_out_valid", {71'h0, out_valid}, 72'h0);
        check("rst_out_instr", {40'h0, out_instr}, 72'h0);
        check("rst_out_pc", {40'h0, out_pc}, 72'h0);
        check("rst_misalign", {71'h0, out_misalign}, 72'h0);

        // Release: still quiet until the first edge after release.
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("rel_pc_ready", {71'h0, pc_ready}, 72'h0);
        tick();
        @(negedge clk);
        check("rel_imem_req", {71'h0, imem_req}, 72'h1);
        tick();
        pc_valid = 1'b0;
        @(negedge clk);
        check("lat_n1_valid", {71'h0, out_valid}, {71'h0, BYP});
`ifdef FETCH_BYPASS_EN
        check("lat_n1_instr", {40'h0, out_instr}, {40'h0, 32'h1234_ffff});
`endif
        tick();
        @(negedge clk);
        check("lat_n2_valid", {71'h0, out_valid}, 72'h1);
        check("lat_n2_pc", {40'h0, out_pc}, 72'h0);
        check("lat_n2_instr", {40'h0, out_instr}, {40'h0, 32'h1234_ffff});
        tick();
        out_ready = 1'b1;
        repeat (2) tick();

        // Streaming: one accept per cycle with decode always ready.
        acc = 0;
        pc_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pc = 32'h0040_0000 + 32'(4 * acc);
            @(negedge clk);
            if (pc_ready) acc++;
            tick();
        end
        check("stream_rate", 72'(acc), 72'd8);
        pc_valid = 1'b0;
        repeat (4) tick();

        // Back-pressure: exactly DEPTH accepts, then stall until a pop.
        out_ready = 1'b0;
        pc_valid  = 1'b1;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            pc = 32'h0040_0200 + 32'(4 * acc);
            @(negedge clk);
            if (pc_ready) acc++;
            tick();
        end
        check("bp_accepts", 72'(acc), 72'd4);
        @(negedge clk);
        check("bp_stalled", {71'h0, pc_ready}, 72'h0);
        pc_valid = 1'b0;
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_at_pop", {71'h0, pc_ready}, 72'h0);
        tick();
        @(negedge clk);
        check("bp_ready_after_pop", {71'h0, pc_ready}, 72'h1);
        repeat (6) tick();
        check("bp_drained", {71'h0, out_valid}, 72'h0);
        check("bp_sb_empty", 72'(exp_q.size()), 72'h0);

        // Flush with count=3 and a response in flight.
        out_ready = 1'b0;
        pc_valid  = 1'b1;
        acc = 0;
        for (int i = 0; i < 20 && acc < 4; i++) begin
            pc = 32'h0040_0300 + 32'(4 * acc);
            @(negedge clk);
            if (pc_ready) acc++;
            tick();
        end
        check("fl_fill", 72'(acc), 72'd4);
        flush = 1'b1;
        @(negedge clk);
        check("fl_no_req", {71'h0, imem_req}, 72'h0);
        check("fl_full_before", {71'h0, out_valid}, 72'h1);
        tick();
        flush = 1'b0;
        pc_valid = 1'b0;
        @(negedge clk);
        check("fl_empty", {71'h0, out_valid}, 72'h0);
        check("fl_ready", {71'h0, pc_ready}, 72'h1);
        tick();
        pc = 32'h0040_0100;
        pc_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        tick();
        pc_valid = 1'b0;
        wait_out(gpc, gmis);
        check("fl_next_pc", {40'h0, gpc}, {40'h0, 32'h0040_0100});
        repeat (3) tick();

        // Misaligned fetch followed by an aligned one.
        pc = 32'h0040_0002;
        pc_valid = 1'b1;
        @(negedge clk);
        tick();
        pc_valid = 1'b0;
        wait_out(gpc, gmis);
        check("mis_pc", {40'h0, gpc}, {40'h0, 32'h0040_0002});
        check("mis_flag", {71'h0, gmis}, 72'h1);
        tick();
        pc = 32'h0040_0004;
        pc_valid = 1'b1;
        @(negedge clk);
        tick();
        pc_valid = 1'b0;
        wait_out(gpc, gmis);
        check("aln_pc", {40'h0, gpc}, {40'h0, 32'h0040_0004});
        check("aln_flag", {71'h0, gmis}, 72'h0);
        repeat (3) tick();

        // Reset mid-flight: state clears at once and the response is lost.
        out_ready = 1'b0;
        pc = 32'h0040_0400;
        pc_valid = 1'b1;
        @(negedge clk);
        tick();
        pc_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("mrst_valid", {71'h0, out_valid}, 72'h0);
        check("mrst_ready", {71'h0, pc_ready}, 72'h0);
        tick();
        reset = 1'b1;
        repeat (4) tick();
        check("mrst_lost", {71'h0, out_valid}, 72'h0);
        check("end_sb_empty", 72'(exp_q.size()), 72'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
